// File: rtl/uart_rx_buffer_pkg.sv
// ============================================================================
// Module  : uart_rx_buffer_pkg
// Brief   : Shared constants for the UART receive buffer: poll FSM states,
//           UART read-select codes and status-byte bit positions.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_rx_buffer_pkg;

  // Poll FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STAT = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] PUSH = 2'd3;

  // UART read-port select codes
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_DATA = 2'b01;
  localparam logic [1:0] RD_STAT = 2'b10;

  // UART status byte bit positions
  localparam int RXRDY = 0;
  localparam int TXRDY = 1;
  localparam int PERR  = 2;
  localparam int FERR  = 3;
  localparam int OVF   = 4;

  function automatic logic [2:0] err_flags(input logic [7:0] status);
    return {status[OVF], status[FERR], status[PERR]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_buffer_sync_fifo.sv
// ============================================================================
// Module  : uart_rx_buffer_sync_fifo
// Brief   : Show-ahead circular FIFO with AW+1 bit wrap pointers; a push into
//           a full FIFO is accepted when a pop retires the head that cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_buffer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  // When full, the slot being written is the head being retired this cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module  : uart_rx_buffer
// Brief   : Polls the UART on each interrupt, reads ready Rx bytes and queues
//           them for the processor. Define UART_RX_ERR_CAPTURE_EN to store
//           the {ovf,ferr,perr} status flags alongside each byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_int,
  input  logic [7:0]    uart_ds,
  output logic [1:0]    uart_read,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic [2:0]    rd_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          drop
);

`ifdef UART_RX_ERR_CAPTURE_EN
  localparam int ENTRY_W = 11;
`else
  localparam int ENTRY_W = 8;
`endif

  logic [1:0]         r_state;
  logic               r_pend;
  logic [1:0]         r_uart_read;
  logic [7:0]         r_byte;
  logic               r_drop;
`ifdef UART_RX_ERR_CAPTURE_EN
  logic [2:0]         r_err;
`endif

  logic               w_push;
  logic               w_full;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  assign w_push = (r_state == PUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_uart_read <= RD_NONE;
      r_byte      <= '0;
`ifdef UART_RX_ERR_CAPTURE_EN
      r_err       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pend) begin
            r_state     <= STAT;
            r_uart_read <= RD_STAT;
          end
        end
        STAT: begin
`ifdef UART_RX_ERR_CAPTURE_EN
          r_err <= err_flags(uart_ds);
`endif
          // A tx-only interrupt ends the poll here.
          if (uart_ds[RXRDY]) begin
            r_state     <= DATA;
            r_uart_read <= RD_DATA;
          end else begin
            r_state     <= IDLE;
            r_uart_read <= RD_NONE;
          end
        end
        DATA: begin
          r_byte      <= uart_ds;
          r_state     <= PUSH;
          r_uart_read <= RD_NONE;
        end
        default: begin
          r_state     <= IDLE;
          r_uart_read <= RD_NONE;
        end
      endcase
    end
  end

  // A new interrupt outranks the clear taken when a poll starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (uart_int) begin
      r_pend <= 1'b1;
    end else if ((r_state == IDLE) && r_pend) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else if (w_push && w_full && !pop) begin
      r_drop <= 1'b1;
    end
  end

`ifdef UART_RX_ERR_CAPTURE_EN
  assign w_wdata = {r_err, r_byte};
  assign rd_data = w_rdata[7:0];
  assign rd_err  = w_rdata[10:8];
`else
  assign w_wdata = r_byte;
  assign rd_data = w_rdata;
  assign rd_err  = 3'b000;
`endif

  uart_rx_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (pop),
    .o_rdata (w_rdata),
    .o_empty (empty),
    .o_full  (w_full),
    .o_count (count)
  );

  assign full      = w_full;
  assign drop      = r_drop;
  assign uart_read = r_uart_read;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module  : tb_uart_rx_buffer
// Brief   : Scoreboard bench for uart_rx_buffer with a behavioural UART
//           read port; popped bytes are checked against queued expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;
  import uart_rx_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          uart_int;
  logic [7:0]    uart_ds;
  logic [1:0]    uart_read;
  logic          pop;
  logic [7:0]    rd_data;
  logic [2:0]    rd_err;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          drop;

  logic [7:0]    stat_v;
  logic [7:0]    data_v;
  logic [10:0]   exp_q[$];
  logic          m_drop;

  int n_checks;
  int n_fail;
  int n_rd11;
  int n_stat_cyc;
  int n_data_cyc;

  uart_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_int  (uart_int),
    .uart_ds   (uart_ds),
    .uart_read (uart_read),
    .pop       (pop),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural UART read port: combinational from the select lines
  always_comb begin
    uart_ds = 8'h00;
    case (uart_read)
      RD_STAT: uart_ds = stat_v;
      RD_DATA: uart_ds = data_v;
      default: uart_ds = 8'h00;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_err(input logic [7:0] st);
`ifdef UART_RX_ERR_CAPTURE_EN
    return {st[4], st[3], st[2]};
`else
    return 3'b000;
`endif
  endfunction

  // Scoreboard monitor: compares the head on every accepted pop strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_read == 2'b11) n_rd11++;
      if (uart_read == RD_STAT) n_stat_cyc++;
      if (uart_read == RD_DATA) n_data_cyc++;
      if (pop) begin
        if (exp_q.size() > 0) begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("pop_empty_flag", 32'(empty), 32'(1'b0));
          check("pop_data", 32'(rd_data), 32'(e[7:0]));
          check("pop_err", 32'(rd_err), 32'(e[10:8]));
        end else begin
          check("pop_when_empty", 32'(empty), 32'(1'b1));
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] st, input logic [7:0] d, input bit pop_at_push);
    stat_v = st;
    data_v = d;
    @(posedge clk); #1 uart_int = 1'b1;
    if (st[0]) begin
      if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back({exp_err(st), d});
      else m_drop = 1'b1;
    end
    @(posedge clk); #1 uart_int = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (pop_at_push) pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_pop();
    @(posedge clk); #1 pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;
  endtask

  initial begin
    int s0;
    int d0;
    n_checks = 0; n_fail = 0; n_rd11 = 0; n_stat_cyc = 0; n_data_cyc = 0;
    rst = 1'b0; uart_int = 1'b0; pop = 1'b0; stat_v = 8'h00; data_v = 8'h00; m_drop = 1'b0;

    // Reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_uart_read", 32'(uart_read), 32'(2'b00));
    check("rst_empty", 32'(empty), 32'(1'b1));
    check("rst_full", 32'(full), 32'(1'b0));
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop), 32'(1'b0));
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_rd_err", 32'(rd_err), 32'(3'b000));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single frame with cycle-exact poll sequence
    stat_v = 8'h01; data_v = 8'h5A;
    exp_q.push_back({exp_err(8'h01), 8'h5A});
    s0 = n_stat_cyc; d0 = n_data_cyc;
    @(posedge clk); #1 uart_int = 1'b1;
    @(posedge clk); #1 uart_int = 1'b0;
    @(negedge clk); check("sf_idle_pend", 32'(uart_read), 32'(2'b00));
    @(negedge clk); check("sf_rd_stat", 32'(uart_read), 32'(2'b10));
    @(negedge clk); check("sf_rd_data", 32'(uart_read), 32'(2'b01));
    @(negedge clk); check("sf_rd_push", 32'(uart_read), 32'(2'b00));
    check("sf_empty_before", 32'(empty), 32'(1'b1));
    @(negedge clk);
    check("sf_empty_after", 32'(empty), 32'(1'b0));
    check("sf_head", 32'(rd_data), 32'h5A);
    check("sf_count", 32'(count), 32'd1);
    check("sf_stat_cycles", 32'(n_stat_cyc - s0), 32'd1);
    check("sf_data_cycles", 32'(n_data_cyc - d0), 32'd1);
    do_pop();
    @(negedge clk); check("sf_drained", 32'(empty), 32'(1'b1));

    // Pop on an empty FIFO is harmless
    do_pop();
    @(negedge clk); check("pop_empty_count", 32'(count), 32'd0);

    // Tx-only interrupt
    s0 = n_stat_cyc; d0 = n_data_cyc;
    send_frame(8'h02, 8'h77, 1'b0);
    check("tx_stat_cycles", 32'(n_stat_cyc - s0), 32'd1);
    check("tx_data_cycles", 32'(n_data_cyc - d0), 32'd0);
    check("tx_count", 32'(count), 32'd0);

    // Interrupt while in DATA: a second status poll follows the push
    stat_v = 8'h01; data_v = 8'h3C;
    exp_q.push_back({exp_err(8'h01), 8'h3C});
    @(posedge clk); #1 uart_int = 1'b1;
    @(posedge clk); #1 uart_int = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 uart_int = 1'b1;
    @(posedge clk); #1 uart_int = 1'b0;
    stat_v = 8'h02;
    @(negedge clk); check("ip_push_rd", 32'(uart_read), 32'(2'b00));
    @(negedge clk); check("ip_idle_rd", 32'(uart_read), 32'(2'b00));
    @(negedge clk); check("ip_second_stat", 32'(uart_read), 32'(2'b10));
    @(negedge clk); check("ip_after_stat", 32'(uart_read), 32'(2'b00));
    check("ip_count", 32'(count), 32'd1);
    do_pop();

    // Fill, overflow drop, simultaneous push/pop at full, ordered drain
    for (int i = 0; i < 16; i++) send_frame(8'h01, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'(1'b1));
    check("fill_count", 32'(count), 32'd16);
    check("fill_no_drop", 32'(drop), 32'(1'b0));
    send_frame(8'h01, 8'hEE, 1'b0);
    check("ovf_drop", 32'(drop), 32'(m_drop));
    check("ovf_count", 32'(count), 32'd16);
    send_frame(8'h01, 8'h20, 1'b1);
    check("sim_count", 32'(count), 32'd16);
    check("sim_full", 32'(full), 32'(1'b1));
    for (int i = 0; i < 16; i++) do_pop();
    @(negedge clk);
    check("drain_empty", 32'(empty), 32'(1'b1));
    check("drain_count", 32'(count), 32'd0);
    check("drain_full", 32'(full), 32'(1'b0));

    // Reset in the middle of a poll
    send_frame(8'h01, 8'h11, 1'b0);
    check("pre_rst_count", 32'(count), 32'd1);
    stat_v = 8'h01; data_v = 8'h99;
    @(posedge clk); #1 uart_int = 1'b1;
    @(posedge clk); #1 uart_int = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_uart_read", 32'(uart_read), 32'(2'b00));
    check("mid_rst_empty", 32'(empty), 32'(1'b1));
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_drop", 32'(drop), 32'(1'b0));
    exp_q.delete();
    m_drop = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;

    // Error flags travel with the byte when capture is built in
    send_frame(8'h09, 8'hA5, 1'b0);
    @(negedge clk);
    check("err_head_data", 32'(rd_data), 32'hA5);
    check("err_head_flags", 32'(rd_err), 32'(exp_err(8'h09)));
    do_pop();

    @(negedge clk);
    check("never_rd11", 32'(n_rd11), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_drop", 32'(drop), 32'(m_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
